// File: rtl/prog_loader_if.sv
// prog_loader_if: streamed program-download channel between the host/UART
// download path (master) and the program loader (slave).
//   dl_start  master->slave  begin a download, dl_base sampled same cycle
//   dl_base   master->slave  first write address / CPU entry address
//   dl_valid  master->slave  dl_data is valid
//   dl_ready  slave->master  loader accepts a word this cycle
//   dl_data   master->slave  instruction word
//   dl_last   master->slave  marks the final word of the image
interface prog_loader_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   dl_start;
  logic [ADDR_WIDTH-1:0]  dl_base;
  logic                   dl_valid;
  logic                   dl_ready;
  logic [INSTR_WIDTH-1:0] dl_data;
  logic                   dl_last;

  modport master (
    output dl_start, dl_base, dl_valid, dl_data, dl_last,
    input  dl_ready
  );

  modport slave (
    input  dl_start, dl_base, dl_valid, dl_data, dl_last,
    output dl_ready
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: instruction memory plus streamed program loader. A download
// starts at a latched base address, auto-increments, and keeps the CPU in
// reset until the image is complete and a short flush has elapsed.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When defined, the word
// accepted with dl_last is a checksum (sum mod 2^INSTR_WIDTH of all earlier
// accepted words) and is not written; a mismatch aborts to IDLE.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   dl             download channel (prog_loader_if.slave)
//   fetch_addr     CPU fetch address
//   fetch_data     registered instruction at fetch_addr (1-cycle latency)
//   cpu_run        CPU run enable, low holds the CPU in reset
//   entry_addr     latched dl_base, CPU reset PC
//   load_count     words written in the current/last load
//   err_overflow   sticky: write past DEPTH-1 attempted
//   err_checksum   sticky: checksum mismatch (0 without the macro)
//
// state | meaning
// IDLE  | no image running, CPU held in reset
// LOAD  | accepting words into memory
// FLUSH | image complete, counting down before release
// RUN   | CPU running from entry_addr
module prog_loader #(
  parameter int INSTR_WIDTH  = 16,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prog_loader_if.slave           dl,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic [INSTR_WIDTH-1:0] fetch_data,
  output logic                   cpu_run,
  output logic [ADDR_WIDTH-1:0]  entry_addr,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   err_overflow,
  output logic                   err_checksum
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // One extra MSB so the pointer can sit at DEPTH without wrapping.
  logic [ADDR_WIDTH:0]    ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]  entry_q, entry_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic [INSTR_WIDTH-1:0] fetch_q;
  logic                   we;
  logic                   last_is_cks;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] sum_q, sum_d;
  logic                   cks_q, cks_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    entry_d     = entry_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    flush_d     = flush_q;
    we          = 1'b0;
    last_is_cks = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    cks_d       = cks_q;
    last_is_cks = dl.dl_last;
`endif
    // dl_start restarts from any state and beats a coincident data word.
    if (dl.dl_start) begin
      state_d = S_LOAD;
      entry_d = dl.dl_base;
      ptr_d   = {1'b0, dl.dl_base};
      count_d = '0;
      ovf_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d   = '0;
      cks_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (dl.dl_valid) begin
            if (!last_is_cks) begin
              if (!ptr_q[ADDR_WIDTH]) begin
                we      = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
`ifdef PROG_LOADER_CHECKSUM_EN
              // Dropped overflow words still count toward the sum.
              sum_d = sum_q + dl.dl_data;
`endif
            end
            if (dl.dl_last) begin
              state_d = S_FLUSH;
              flush_d = FW'(FLUSH_CYCLES);
`ifdef PROG_LOADER_CHECKSUM_EN
              if (sum_q != dl.dl_data) begin
                state_d = S_IDLE;
                cks_d   = 1'b1;
              end
`endif
            end
          end
        end
        S_FLUSH: begin
          if (flush_q == '0) state_d = S_RUN;
          else               flush_d = flush_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      entry_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      flush_q <= '0;
      fetch_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      cks_q   <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      entry_q <= entry_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      flush_q <= flush_d;
      fetch_q <= mem[fetch_addr];
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      cks_q   <= cks_d;
`endif
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q[ADDR_WIDTH-1:0]] <= dl.dl_data;
  end

  assign dl.dl_ready   = (state_q == S_LOAD);
  assign cpu_run       = (state_q == S_RUN);
  assign fetch_data    = fetch_q;
  assign entry_addr    = entry_q;
  assign load_count    = count_q;
  assign err_overflow  = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err_checksum  = cks_q;
`else
  assign err_checksum  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int IW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] fetch_addr;
  logic [IW-1:0] fetch_data;
  logic          cpu_run;
  logic [AW-1:0] entry_addr;
  logic [AW:0]   load_count;
  logic          err_overflow;
  logic          err_checksum;

  int total = 0;
  int bad   = 0;

  prog_loader_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dl ();

  prog_loader #(.INSTR_WIDTH(IW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dl           (dl.slave),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .cpu_run      (cpu_run),
    .entry_addr   (entry_addr),
    .load_count   (load_count),
    .err_overflow (err_overflow),
    .err_checksum (err_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [IW-1:0] exp;
  } fetch_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] base);
    dl.dl_start = 1'b1;
    dl.dl_base  = base;
    tick();
    dl.dl_start = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] data, input logic last);
    dl.dl_valid = 1'b1;
    dl.dl_data  = data;
    dl.dl_last  = last;
    tick();
    dl.dl_valid = 1'b0;
    dl.dl_last  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] addr, output logic [IW-1:0] data);
    fetch_addr = addr;
    tick();
    data = fetch_data;
  endtask

  task automatic wait_run(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!cpu_run && n < 20) begin
      tick();
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  task automatic run_table(input fetch_vec_t tbl[$]);
    logic [IW-1:0] d;
    foreach (tbl[i]) begin
      fetch(tbl[i].addr, d);
      chk(tbl[i].name, d, tbl[i].exp);
    end
  endtask

  initial begin
    fetch_vec_t    tbl[$];
    logic [IW-1:0] d;

    rst_n       = 1'b0;
    dl.dl_start = 1'b0;
    dl.dl_base  = '0;
    dl.dl_valid = 1'b0;
    dl.dl_data  = '0;
    dl.dl_last  = 1'b0;
    fetch_addr  = '0;
    #12;
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_dl_ready", dl.dl_ready, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_entry", entry_addr, 0);
    chk("rst_count", load_count, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_cks", err_checksum, 0);
    rst_n = 1'b1;
    tick();

`ifndef PROG_LOADER_CHECKSUM_EN
    // Basic load and run at base 10.
    start(8'd10);
    chk("basic_ready", dl.dl_ready, 1);
    chk("basic_entry", entry_addr, 10);
    send(16'h2005, 1'b0);
    send(16'h1FC2, 1'b0);
    send(16'hE7FE, 1'b1);
    chk("basic_run_low_after_last", cpu_run, 0);
    wait_run("basic_run_latency", 3);
    chk("basic_count", load_count, 3);
    chk("basic_ready_run", dl.dl_ready, 0);
    chk("basic_ovf", err_overflow, 0);
    tbl = '{
      '{"basic_m10", 8'd10, 16'h2005},
      '{"basic_m11", 8'd11, 16'h1FC2},
      '{"basic_m12", 8'd12, 16'hE7FE}
    };
    run_table(tbl);

    // Backpressure gaps at base 20, started from RUN.
    start(8'd20);
    chk("bp_run_dropped", cpu_run, 0);
    send(16'h2005, 1'b0);
    tick(); tick();
    send(16'h1FC2, 1'b0);
    tick(); tick();
    send(16'hE7FE, 1'b1);
    wait_run("bp_run_latency", 3);
    chk("bp_count", load_count, 3);
    tbl = '{
      '{"bp_m20", 8'd20, 16'h2005},
      '{"bp_m21", 8'd21, 16'h1FC2},
      '{"bp_m22", 8'd22, 16'hE7FE}
    };
    run_table(tbl);

    // Overflow: seed mem[0..1], then load 4 words at DEPTH-2.
    start(8'd0);
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b1);
    wait_run("seed_run", 3);
    start(8'(DEPTH - 2));
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b1);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_count", load_count, 2);
    wait_run("ovf_run_latency", 3);
    tbl = '{
      '{"ovf_m254", 8'd254, 16'h1111},
      '{"ovf_m255", 8'd255, 16'h2222},
      '{"ovf_m0",   8'd0,   16'hAAAA},
      '{"ovf_m1",   8'd1,   16'h5555}
    };
    run_table(tbl);

    // Restart from RUN clears the sticky error and drops cpu_run.
    start(8'd32);
    chk("rs_run_dropped", cpu_run, 0);
    chk("rs_ovf_cleared", err_overflow, 0);
    chk("rs_count_cleared", load_count, 0);
    send(16'h9999, 1'b1);
    wait_run("rs_seed_run", 3);

    // Restart coinciding with a valid word: word must not land at ptr 32.
    start(8'd30);
    send(16'h7777, 1'b0);
    send(16'h8888, 1'b0);
    dl.dl_start = 1'b1;
    dl.dl_base  = 8'd40;
    dl.dl_valid = 1'b1;
    dl.dl_data  = 16'hBAD0;
    dl.dl_last  = 1'b0;
    tick();
    dl.dl_start = 1'b0;
    dl.dl_valid = 1'b0;
    chk("rsv_count", load_count, 0);
    chk("rsv_entry", entry_addr, 40);
    send(16'h0123, 1'b1);
    chk("rsv_count_after", load_count, 1);
    wait_run("rsv_run_latency", 3);
    tbl = '{
      '{"rsv_m30", 8'd30, 16'h7777},
      '{"rsv_m31", 8'd31, 16'h8888},
      '{"rsv_m32", 8'd32, 16'h9999},
      '{"rsv_m40", 8'd40, 16'h0123}
    };
    run_table(tbl);

    // Asynchronous reset mid-load.
    fetch(8'd10, d);
    chk("ar_pre_fetch", d, 16'h2005);
    start(8'd50);
    send(16'hC0DE, 1'b0);
    chk("ar_pre_ready", dl.dl_ready, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_cpu_run", cpu_run, 0);
    chk("ar_ready", dl.dl_ready, 0);
    chk("ar_fetch_data", fetch_data, 0);
    #2;
    rst_n = 1'b1;
    tick();
    fetch(8'd50, d);
    chk("ar_partial_kept", d, 16'hC0DE);
    tick(); tick(); tick(); tick();
    chk("ar_stays_idle", cpu_run, 0);
    chk("ar_entry", entry_addr, 0);
`else
    // Checksum good.
    start(8'd60);
    send(16'h2005, 1'b0);
    send(16'h1FC2, 1'b0);
    send(16'h3FC7, 1'b1);
    wait_run("cks_good_run", 3);
    chk("cks_good_count", load_count, 2);
    chk("cks_good_flag", err_checksum, 0);
    tbl = '{
      '{"cks_m60", 8'd60, 16'h2005},
      '{"cks_m61", 8'd61, 16'h1FC2}
    };
    run_table(tbl);

    // Checksum bad.
    start(8'd70);
    send(16'h2005, 1'b0);
    send(16'h1FC2, 1'b0);
    send(16'h3FC8, 1'b1);
    chk("cks_bad_flag", err_checksum, 1);
    chk("cks_bad_count", load_count, 2);
    chk("cks_bad_ready", dl.dl_ready, 0);
    tick(); tick(); tick(); tick(); tick();
    chk("cks_bad_no_run", cpu_run, 0);
    chk("cks_bad_flag_sticky", err_checksum, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program loader and instruction memory for the CPU. It replaces the single-word `download_program` / `instruction_index` / `program_in` poke interface with a streamed valid/ready download. The download starts at a latched base address, auto-increments, and holds the CPU in reset until the image is complete. It sits between the host/UART download path and the CPU fetch port and owns the CPU run enable.

## Interface
Parameters:
- `INSTR_WIDTH`, 16, instruction word width in bits.
- `DEPTH`, 256, number of instruction words; a power of two, ≥ 4.
- `ADDR_WIDTH`, $clog2(DEPTH), address width.
- `FLUSH_CYCLES`, 2, cycles `cpu_run` stays low after a successful load.

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `dl_start` input 1: begin a download; `dl_base` is sampled on the same cycle.
- `dl_base` input ADDR_WIDTH: first write address, which is also the CPU entry address.
- `dl_valid` input 1: `dl_data` is valid.
- `dl_ready` output 1: loader accepts a word this cycle.
- `dl_data` input INSTR_WIDTH: instruction word.
- `dl_last` input 1: qualifies the final accepted word of the image.
- `fetch_addr` input ADDR_WIDTH: CPU fetch address.
- `fetch_data` output INSTR_WIDTH: instruction at `fetch_addr`, registered.
- `cpu_run` output 1: CPU run enable; low means the CPU is held in reset.
- `entry_addr` output ADDR_WIDTH: latched `dl_base`, used as the CPU reset PC.
- `load_count` output ADDR_WIDTH+1: words written in the current or last load.
- `err_overflow` output 1: sticky; a write past `DEPTH-1` was attempted.
- `err_checksum` output 1: sticky; checksum mismatch (only when the macro is defined).

## Operation
- **States:** IDLE, LOAD, FLUSH, RUN.
- **Reset state:** IDLE. Reset values:
  - `cpu_run`=0, `dl_ready`=0, `fetch_data`=0, `entry_addr`=0, `load_count`=0.
  - Both error flags are 0.
  - Memory contents are not reset.
- **Starting a load:** `dl_start` in IDLE or RUN moves to LOAD. On that edge:
  - latch `entry_addr`←`dl_base` and the write pointer←`dl_base`;
  - clear `load_count` and both error flags;
  - drive `cpu_run` low.
- **`dl_start` in LOAD or FLUSH** restarts the load with the new base. Words written before the restart stay in memory.
- **LOAD:** `dl_ready`=1. A word is accepted when `dl_valid` & `dl_ready`. Each accepted word:
  - writes `mem[ptr]`;
  - increments `ptr` and `load_count`.
- **Overflow:** if an accepted word arrives with `ptr` already past `DEPTH-1` (the pointer does not wrap):
  - the word is dropped and `err_overflow` is set;
  - the load continues so that `dl_last` is still honoured.
- **Finishing a load:** an accepted word with `dl_last` moves to FLUSH, or to IDLE when the checksum fails.
- **FLUSH:** counts `FLUSH_CYCLES`, then enters RUN. On RUN entry `cpu_run`=1.
- **Overflow and RUN:** a load with `err_overflow` set still reaches RUN. Host software checks the flag.
- **RUN:** `cpu_run`=1 and `dl_ready`=0. Only `dl_start` leaves RUN.
- **Fetch path:** `fetch_data` ← `mem[fetch_addr]` on every edge in every state. Fetches during LOAD return possibly stale data; the CPU is held in reset then, so this is harmless.

## Timing
- **Fetch latency:** one cycle, from `fetch_addr` to `fetch_data`.
- **Write:** takes effect on the accepting edge. A fetch of the same address on the next cycle returns the new word.
- **Start to ready:** `dl_start` at edge N gives `dl_ready`=1 from after edge N. The first word can be accepted at edge N+1.
- **Last word to run:** last word accepted at edge M gives `cpu_run`=1 after edge M+1+`FLUSH_CYCLES`.
- **`dl_start` together with `dl_valid` in LOAD:** the restart wins and the word is not written.
- **`rst_n` asserted mid-load:**
  - immediate return to IDLE with `cpu_run`=0;
  - the partial image stays in memory but is not run.
- **`load_count` width:** ADDR_WIDTH+1, so a full-`DEPTH` load reports `DEPTH` without wrapping.

## Configuration
- **`PROG_LOADER_CHECKSUM_EN` defined:**
  - the word accepted with `dl_last` is a checksum, and it is not written to memory;
  - the loader keeps a running sum modulo 2^INSTR_WIDTH of all preceding accepted words, including dropped overflow words;
  - on equality the loader enters FLUSH;
  - on mismatch it sets `err_checksum`, enters IDLE, and `cpu_run` stays 0.
- **Macro not defined:**
  - the `dl_last` word is an ordinary instruction and is written;
  - `err_checksum` is tied to 0 and no adder is built.

## Test plan
- **Basic load and run:** reset; `dl_start` with `dl_base`=10; stream 0x2005, 0x1FC2, 0xE7FE with `dl_last` on the third word.
  - `mem[10..12]` hold those words; `load_count`=3; `entry_addr`=10;
  - `cpu_run` rises 3 cycles after the last accept;
  - fetching addresses 10, 11, 12 returns the words with 1-cycle latency.
- **Backpressure gaps:** same image with `dl_valid` low for 2 cycles between words → identical memory contents and `load_count`=3.
- **Overflow:** `dl_base`=DEPTH-2; stream 4 words with last.
  - `mem[DEPTH-2]` and `mem[DEPTH-1]` are written; `mem[0]` and `mem[1]` are unchanged;
  - `err_overflow`=1, `load_count`=2, RUN is reached.
- **Restart:**
  - `dl_start` in RUN drops `cpu_run` on the next edge and clears the error flags;
  - `dl_start` asserted together with `dl_valid` mid-load → the word is not written and `ptr` equals the new `dl_base`.
- **Asynchronous reset:** `rst_n` low between clock edges during LOAD → `cpu_run`=0, `dl_ready`=0 and `fetch_data`=0 immediately, with no clock edge needed.
- **Checksum (macro defined):** words 0x2005, 0x1FC2, then last=0x3FC7 → RUN reached. Last=0x3FC8 instead → `err_checksum`=1, state IDLE, `cpu_run`=0, `load_count`=2.
